// File: rtl/uart_mem_dumper.sv
// uart_mem_dumper: streams program memory out over UART as SYNC, MSB-first words, then an 8-bit checksum.
module uart_mem_dumper #(
  parameter int COMMAND_WIDTH = 32,
  parameter int PROGRAM_MEM_SIZE = 256,
  parameter int TX_DATA_WIDTH = 8,
  parameter logic [TX_DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5
) (
  input  logic                                in_clk,
  input  logic                                in_rst,
  input  logic                                in_clke,
  input  logic                                in_dump,
  input  logic                                in_abort,
  output logic                                out_mem_rd_reg,
  output logic [$clog2(PROGRAM_MEM_SIZE)-1:0] out_mem_addr_reg,
  input  logic [COMMAND_WIDTH-1:0]            in_mem_data,
  output logic                                out_uart_tx_start_reg,
  output logic [TX_DATA_WIDTH-1:0]            out_uart_tx_data_reg,
  input  logic                                in_uart_tx_done,
  output logic                                out_cpu_halt_reg,
  output logic                                out_busy_reg,
  output logic                                out_done_reg
);
  localparam int AW = $clog2(PROGRAM_MEM_SIZE);
  localparam int BYTES = COMMAND_WIDTH / TX_DATA_WIDTH;
  localparam int IW = $clog2(BYTES + 1);
  typedef enum logic [3:0] {
    IDLE, SEND_SYNC, WAIT_SYNC, RD_REQ, RD_WAIT, LOAD,
    SEND_BYTE, WAIT_BYTE, NEXT, SEND_SUM, WAIT_SUM, DONE
  } state_t;
  state_t                     r_state, w_next;
  logic                       r_start, r_rd, r_done, r_busy;
  logic [AW-1:0]              r_addr;
  logic [TX_DATA_WIDTH-1:0]   r_data, r_sum, w_byte;
  logic [COMMAND_WIDTH-1:0]   r_shift, w_src;
  logic [IW-1:0]              r_idx;
  logic                       w_send;
  assign out_mem_rd_reg        = r_rd;
  assign out_mem_addr_reg      = r_addr;
  assign out_uart_tx_start_reg = r_start;
  assign out_uart_tx_data_reg  = r_data;
  assign out_cpu_halt_reg      = r_busy;
  assign out_busy_reg          = r_busy;
  assign out_done_reg          = r_done;
  assign w_src  = (r_state == LOAD) ? in_mem_data : r_shift << TX_DATA_WIDTH;
  assign w_byte = w_src[COMMAND_WIDTH-1 -: TX_DATA_WIDTH];
  assign w_send = w_next inside {SEND_SYNC, SEND_BYTE, SEND_SUM};
  always_ff @(posedge in_clk or negedge in_rst)
    if (!in_rst) r_state <= IDLE;
    else         r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (in_clke) begin
      if (in_abort && r_state != IDLE) w_next = IDLE;
      else
        case (r_state)
          IDLE:      w_next = in_dump ? SEND_SYNC : IDLE;
          SEND_SYNC: w_next = WAIT_SYNC;
          WAIT_SYNC: w_next = in_uart_tx_done ? RD_REQ : WAIT_SYNC;
          RD_REQ:    w_next = RD_WAIT;
          RD_WAIT:   w_next = LOAD;
          LOAD:      w_next = SEND_BYTE;
          SEND_BYTE: w_next = WAIT_BYTE;
          WAIT_BYTE: w_next = !in_uart_tx_done ? WAIT_BYTE :
                              (r_idx == IW'(BYTES - 1)) ? NEXT : SEND_BYTE;
          NEXT:      w_next = (r_addr == AW'(PROGRAM_MEM_SIZE - 1)) ? SEND_SUM : RD_REQ;
          SEND_SUM:  w_next = WAIT_SUM;
          WAIT_SUM:  w_next = in_uart_tx_done ? DONE : WAIT_SUM;
          DONE:      w_next = IDLE;
          default:   w_next = IDLE;
        endcase
    end
  end
  // Strobes are set only on the entering edge, so a stalled clke never stretches them.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_start <= 1'b0;
      r_rd    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_sum   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      r_start <= in_clke && w_send;
      r_rd    <= in_clke && w_next == RD_REQ;
      r_done  <= in_clke && w_next == DONE;
      if (in_clke) r_busy <= w_next != IDLE;
      if (r_state == IDLE && w_next == SEND_SYNC) begin
        r_addr <= '0;
        r_sum  <= '0;
        r_data <= SYNC_BYTE;
      end
      if (r_state == NEXT && w_next == RD_REQ) r_addr <= r_addr + AW'(1);
      if (r_state != SEND_BYTE && w_next == SEND_BYTE) begin
        r_shift <= w_src;
        r_data  <= w_byte;
        r_sum   <= r_sum + w_byte;
      end
      if (r_state != SEND_SUM && w_next == SEND_SUM) r_data <= r_sum;
      if (r_state == LOAD) r_idx <= '0;
      else if (r_state == WAIT_BYTE && w_next != WAIT_BYTE) r_idx <= r_idx + IW'(1);
    end
  end
endmodule

// File: tb/tb_uart_mem_dumper.sv
// tb_uart_mem_dumper: scoreboard bench with a UART/memory model around a 4-word, 16-bit dumper.
module tb_uart_mem_dumper;
  logic clk = 1'b0, rst_n = 1'b0, clke = 1'b1, dump = 1'b0, abort = 1'b0, tx_done = 1'b0;
  logic [15:0] mem_data = '0;
  logic rd, start, busy, halt, done_o;
  logic [1:0] addr;
  logic [7:0] data;
  logic [15:0] mem [4] = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};
  logic [7:0] frame [10] = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00, 8'hBE};
  logic [7:0] exp_q [$];
  logic [1:0] addr_q [$];
  logic [7:0] last_data = '0;
  int errors = 0, checks = 0, bytes_sent = 0, done_cnt = 0, cnt = 0, b0 = 0;
  bit toggle = 0, spur_arm = 0, spur_next = 0, prev_start = 0;

  uart_mem_dumper #(.COMMAND_WIDTH(16), .PROGRAM_MEM_SIZE(4), .TX_DATA_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
    .in_clk(clk), .in_rst(rst_n), .in_clke(clke), .in_dump(dump), .in_abort(abort),
    .out_mem_rd_reg(rd), .out_mem_addr_reg(addr), .in_mem_data(mem_data),
    .out_uart_tx_start_reg(start), .out_uart_tx_data_reg(data), .in_uart_tx_done(tx_done),
    .out_cpu_halt_reg(halt), .out_busy_reg(busy), .out_done_reg(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input int nb, input int na);
    for (int i = 0; i < nb; i++) exp_q.push_back(frame[i]);
    for (int i = 0; i < na; i++) addr_q.push_back(2'(i));
  endtask

  task automatic kick();
    @(negedge clk); dump = 1'b1;
    @(negedge clk); dump = 1'b0;
  endtask

  task automatic wait_bytes(input int target);
    for (int i = 0; i < 500 && bytes_sent < target; i++) @(negedge clk);
    chk("wait_bytes_timeout", 32'(bytes_sent >= target), 1);
  endtask

  task automatic wait_done(input int target, input int lim);
    for (int i = 0; i < lim && done_cnt < target; i++) @(negedge clk);
    chk("wait_done_timeout", 32'(done_cnt >= target), 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_rd"}, 32'(rd), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_halt"}, 32'(halt), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
  endtask

  task automatic frame_end(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_bytes"}, 32'(bytes_sent - b0), 10);
    chk({tag, "_queues_empty"}, 32'(exp_q.size() + addr_q.size()), 0);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_halt_after"}, 32'(halt), 0);
  endtask

  // UART and memory model: tx_done ten cycles after each start, only on an enabled cycle.
  initial forever begin
    @(negedge clk);
    clke = toggle ? ~clke : 1'b1;
    tx_done = 1'b0;
    if (!rst_n) cnt = 0;
    else begin
      if (rd) mem_data = mem[addr];
      if (spur_next) begin tx_done = 1'b1; spur_next = 0; end
      if (spur_arm && rd) begin spur_arm = 0; spur_next = 1; end
      if (start) cnt = 10;
      else if (cnt > 1) cnt--;
      else if (cnt == 1 && clke) begin tx_done = 1'b1; cnt = 0; end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) prev_start = 0;
    else begin
      if (start) begin
        chk("start_one_cycle", 32'(prev_start), 0);
        chk("halt_during_tx", 32'(halt), 1);
        if (exp_q.size() == 0) chk("tx_byte_unexpected", 32'(data), 32'hFFFF_FFFF);
        else chk("tx_byte", 32'(data), 32'(exp_q.pop_front()));
        last_data = data;
        bytes_sent++;
      end else if (busy) chk("tx_data_hold", 32'(data), 32'(last_data));
      if (rd) begin
        if (addr_q.size() == 0) chk("rd_unexpected", 32'(addr), 32'hFFFF_FFFF);
        else chk("rd_addr", 32'(addr), 32'(addr_q.pop_front()));
      end
      if (done_o) done_cnt++;
      prev_start = start;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    b0 = bytes_sent;
    push(10, 4);
    @(negedge clk); dump = 1'b1;
    @(negedge clk);
    chk("latency_start", 32'(start), 1);
    chk("sync_data", 32'(data), 32'hA5);
    chk("busy_at_start", 32'(busy), 1);
    dump = 1'b0;
    wait_done(1, 1500);
    repeat (5) @(negedge clk);
    chk("done_once", 32'(done_cnt), 1);
    frame_end("basic");

    b0 = bytes_sent;
    push(10, 4);
    spur_arm = 1;
    kick();
    repeat (40) @(negedge clk);
    chk("busy_mid_frame", 32'(busy), 1);
    dump = 1'b1;
    @(negedge clk); dump = 1'b0;
    wait_done(2, 1500);
    frame_end("spur");

    b0 = bytes_sent;
    push(3, 1);
    kick();
    wait_bytes(b0 + 3);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_halt", 32'(halt), 0);
    chk("abort_start", 32'(start), 0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 2);
    chk("abort_bytes", 32'(bytes_sent - b0), 3);
    chk("abort_queues", 32'(exp_q.size() + addr_q.size()), 0);
    b0 = bytes_sent;
    push(10, 4);
    kick();
    wait_done(3, 1500);
    frame_end("after_abort");

    b0 = bytes_sent;
    push(3, 1);
    kick();
    wait_bytes(b0 + 3);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_queues", 32'(exp_q.size() + addr_q.size()), 0);
    b0 = bytes_sent;
    push(10, 4);
    kick();
    wait_done(4, 1500);
    frame_end("after_rst");

    toggle = 1;
    b0 = bytes_sent;
    push(10, 4);
    @(negedge clk); dump = 1'b1;
    repeat (2) @(negedge clk);
    dump = 1'b0;
    wait_done(5, 3000);
    toggle = 0;
    frame_end("clke");
    chk("done_total", 32'(done_cnt), 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
